// File: rtl/aes256_key_expander_pkg.sv
// Shared AES-256 key-schedule definitions: S-box, round constants, word helpers, FSM state type.
package aes256_key_expander_pkg;

  localparam int unsigned NK      = 8;
  localparam int unsigned NR      = 14;
  localparam int unsigned NWORDS  = 4 * (NR + 1);
  localparam int unsigned CHAIN_W = 32 * NWORDS;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {StIdle, StExpand, StDone} keyexp_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Only indices 1..7 are reached by AES-256; 0 maps to zero.
  function automatic logic [7:0] rcon(input logic [2:0] r);
    case (r)
      3'd1:    return 8'h01;
      3'd2:    return 8'h02;
      3'd3:    return 8'h04;
      3'd4:    return 8'h08;
      3'd5:    return 8'h10;
      3'd6:    return 8'h20;
      3'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes256_key_expander_if.sv
// Key handshake and round-key chain bundle between key source, expander and consumer.
interface aes256_key_expander_if;
  import aes256_key_expander_pkg::*;

  logic [32*NK-1:0]   key_i;
  logic               key_v_i;
  logic               key_ready_o;
  logic [CHAIN_W-1:0] key_chain_o;
  logic               key_chain_v_o;

  modport master (
    output key_i,
    output key_v_i,
    input  key_ready_o,
    input  key_chain_o,
    input  key_chain_v_o
  );

  modport slave (
    input  key_i,
    input  key_v_i,
    output key_ready_o,
    output key_chain_o,
    output key_chain_v_o
  );
endinterface

// File: rtl/aes256_key_expander_sbox_word.sv
// 32-bit SubWord: four parallel S-box lookups, purely combinational.
module aes256_key_expander_sbox_word
  import aes256_key_expander_pkg::*;
(
  input  aes_word_t data,
  output aes_word_t result
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign result[8*b +: 8] = SBOX[data[8*b +: 8]];
  end

endmodule

// File: rtl/aes256_key_expander.sv
// Iterative AES-256 key schedule, one word per cycle. Optional zeroize_i when
// AES_KEYEXP_ZEROIZE_EN is defined.
module aes256_key_expander
  import aes256_key_expander_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic                 zeroize_i,
`endif
  aes256_key_expander_if.slave kx
);

  keyexp_state_e      state_q;
  logic [5:0]         idx_q;
  logic [CHAIN_W-1:0] chain_q;
  logic               valid_q;

  logic      clear;
  aes_word_t words [64];
  aes_word_t w_prev, w_back, sub_in, sub_out, temp, w_new;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign clear = reset_i | zeroize_i;
`else
  assign clear = reset_i;
`endif

  // Word view of the chain, padded to 64 so a 6-bit index never leaves the array.
  for (genvar g = 0; g < 64; g++) begin : g_words
    if (g < NWORDS) begin : g_real
      assign words[g] = chain_q[CHAIN_W-1-32*g -: 32];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end

  assign w_prev = words[idx_q - 6'd1];
  assign w_back = words[idx_q - 6'(NK)];
  assign sub_in = (idx_q[2:0] == 3'd0) ? rot_word(w_prev) : w_prev;

  aes256_key_expander_sbox_word u_sbox (
    .data   (sub_in),
    .result (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (idx_q[2:0] == 3'd0) begin
      temp = sub_out ^ {rcon(idx_q[5:3]), 24'h0};
    end else if (idx_q[2:0] == 3'd4) begin
      temp = sub_out;
    end
    w_new = w_back ^ temp;
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q <= StIdle;
      idx_q   <= '0;
      chain_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (kx.key_v_i) begin
            chain_q[CHAIN_W-1 -: 32*NK] <= kx.key_i;
            idx_q   <= 6'(NK);
            valid_q <= 1'b0;
            state_q <= StExpand;
          end
        end
        StExpand: begin
          for (int g = NK; g < NWORDS; g++) begin
            if (idx_q == 6'(g)) chain_q[CHAIN_W-1-32*g -: 32] <= w_new;
          end
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'(NWORDS - 1)) begin
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign kx.key_ready_o   = (state_q == StIdle) || (state_q == StDone);
  assign kx.key_chain_o   = chain_q;
  assign kx.key_chain_v_o = valid_q;

endmodule

// File: tb/tb_aes256_key_expander.sv
// Self-checking bench for aes256_key_expander: known-answer table, random keys against a
// GF(2^8)-derived reference schedule, and handshake/reset/zeroize corner sequences.
module tb_aes256_key_expander;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  aes256_key_expander_if kx_if ();

  aes256_key_expander dut (
    .clk_i     (clk),
    .reset_i   (reset),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize_i (zeroize),
`endif
    .kx        (kx_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox_m [256];

  typedef struct {
    string          name;
    logic [255:0]   key;
    int             rk;
    logic [127:0]   exp;
  } vec_t;

  vec_t vecs [6];

  // ---------------- reference model (field arithmetic, FIPS-197 loop) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_m[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  function automatic logic [1919:0] expand_ref(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] r;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_chain(input string name, input logic [1919:0] exp);
    n_checks++;
    if (kx_if.key_chain_o !== exp) begin
      int i = 0;
      n_fail++;
      while (i < 59 && kx_if.key_chain_o[1919-32*i -: 32] === exp[1919-32*i -: 32]) i++;
      $display("FAIL %s: w[%0d] got %h expected %h", name, i,
               kx_if.key_chain_o[1919-32*i -: 32], exp[1919-32*i -: 32]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a key for one edge; returns after the accept edge.
  task automatic accept(input logic [255:0] key);
    kx_if.key_i   = key;
    kx_if.key_v_i = 1'b1;
    step();
    kx_if.key_v_i = 1'b0;
  endtask

  // Counts edges after the accept edge until valid rises (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!kx_if.key_chain_v_o && n < 200) begin
      step();
      n++;
    end
  endtask

  localparam logic [255:0] KEY_SEQ =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] ka, kb;
    int n;

    kx_if.key_i   = '0;
    kx_if.key_v_i = 1'b0;
    build_sbox();

    vecs[0] = '{"seq_rk0",  KEY_SEQ, 0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{"seq_rk1",  KEY_SEQ, 1,  128'h101112131415161718191a1b1c1d1e1f};
    vecs[2] = '{"seq_rk2",  KEY_SEQ, 2,  128'ha573c29fa176c498a97fce93a572c09c};
    vecs[3] = '{"seq_rk14", KEY_SEQ, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[4] = '{"zero_rk2", 256'h0,  2,  128'h62636363626363636263636362636363};
    vecs[5] = '{"zero_rk3", 256'h0,  3,  128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb};

    repeat (2) step();
    reset = 1'b0;
    check_val("reset_ready", 128'(kx_if.key_ready_o), 128'd1);
    check_val("reset_valid", 128'(kx_if.key_chain_v_o), 128'd0);
    check_chain("reset_chain", '0);

    // Known-answer table.
    for (int v = 0; v < 6; v++) begin
      accept(vecs[v].key);
      check_val({vecs[v].name, "_ready_busy"}, 128'(kx_if.key_ready_o), 128'd0);
      wait_valid(n);
      check_val({vecs[v].name, "_latency"}, 128'(n), 128'd52);
      check_val(vecs[v].name, kx_if.key_chain_o[1919-128*vecs[v].rk -: 128], vecs[v].exp);
    end

    // Random keys against the reference model.
    for (int r = 0; r < 8; r++) begin
      ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      accept(ka);
      wait_valid(n);
      check_chain($sformatf("random_%0d", r), expand_ref(ka));
    end

    // key_v_i held high with a changing key through EXPAND.
    ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    kx_if.key_i   = ka;
    kx_if.key_v_i = 1'b1;
    step();
    n = 0;
    while (!kx_if.key_chain_v_o && n < 200) begin
      kx_if.key_i = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
      if (n == 10) check_val("hold_ready_low", 128'(kx_if.key_ready_o), 128'd0);
      step();
      n++;
    end
    kx_if.key_v_i = 1'b0;
    check_val("hold_latency", 128'(n), 128'd52);
    check_chain("hold_chain", expand_ref(ka));

    // Back-to-back: second key in the first DONE cycle.
    ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    accept(ka);
    wait_valid(n);
    check_chain("b2b_first", expand_ref(ka));
    accept(kb);
    check_val("b2b_valid_drop", 128'(kx_if.key_chain_v_o), 128'd0);
    wait_valid(n);
    check_val("b2b_latency", 128'(n), 128'd52);
    check_chain("b2b_second", expand_ref(kb));

    // Reset 20 cycles into EXPAND, then a fresh key.
    accept(ka);
    repeat (20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_chain("midreset_chain", '0);
    check_val("midreset_valid", 128'(kx_if.key_chain_v_o), 128'd0);
    check_val("midreset_ready", 128'(kx_if.key_ready_o), 128'd1);
    accept(kb);
    wait_valid(n);
    check_val("midreset_latency", 128'(n), 128'd52);
    check_chain("midreset_fresh", expand_ref(kb));

`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    check_chain("zeroize_chain", '0);
    check_val("zeroize_valid", 128'(kx_if.key_chain_v_o), 128'd0);
    check_val("zeroize_ready", 128'(kx_if.key_ready_o), 128'd1);
    zeroize = 1'b1;
    accept(ka);
    zeroize = 1'b0;
    check_val("zeroize_wins_ready", 128'(kx_if.key_ready_o), 128'd1);
    check_chain("zeroize_wins_chain", '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
